// File: rtl/command_frame_receiver.sv
// command_frame_receiver
// Receive side of the host-to-FPGA command link. Deserialises 8N1 UART bytes
// and assembles them into opcode frames. Opcodes whose low nibble is F or 7
// carry a 16-bit argument, sent MSB byte first.
module command_frame_receiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter int GAP_TIMEOUT  = 17360
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        RsRx,
  output logic [7:0]  Command,
  output logic [15:0] Argument,
  output logic        Rx_Ready,
  output logic        Frame_Error,
  output logic        Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAITHI
  } rx_state_t;

  typedef enum logic [1:0] {
    F_OPCODE,
    F_ARG_HI,
    F_ARG_LO
  } frame_state_t;

  // synchroniser and edge detector
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic rx_prev_q, rx_prev_d;
  logic rx_s;
  logic start_det;

  // bit FSM
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             byte_err_q, byte_err_d;

  // frame FSM and gap timer
  frame_state_t     frame_state_q, frame_state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             gap_run;
  logic             gap_expire;
  logic [7:0]       opcode_q, opcode_d;
  logic [7:0]       arg_hi_q, arg_hi_d;
  logic [7:0]       command_q, command_d;
  logic [15:0]      argument_q, argument_d;
  logic             rx_ready_q, rx_ready_d;
  logic             frame_error_q, frame_error_d;

  assign rx_s      = sync2_q;
  assign start_det = rx_prev_q & ~sync2_q;

  // Two-flop synchroniser on the raw line plus a delayed copy for edge detection
  always_comb begin
    sync1_d   = RsRx;
    sync2_d   = sync1_q;
    rx_prev_d = sync2_q;
  end

  // Bit-level receiver: mid-bit sampling of start, data and stop bits
  always_comb begin
    rx_state_d   = rx_state_q;
    bit_cnt_d    = bit_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    byte_err_d   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (start_det) begin
          rx_state_d = RX_START;
          bit_cnt_d  = CNT_W'(CLKS_PER_BIT / 2 - 1);
        end
      end
      RX_START: begin
        if (bit_cnt_q == '0) begin
          if (rx_s) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            bit_cnt_d  = CNT_W'(CLKS_PER_BIT - 1);
            bit_idx_d  = 3'd0;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (bit_cnt_q == '0) begin
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = CNT_W'(CLKS_PER_BIT - 1);
          if (bit_idx_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (bit_cnt_q == '0) begin
          if (rx_s) begin
            byte_valid_d = 1'b1;
            rx_state_d   = RX_IDLE;
          end else begin
            byte_err_d = 1'b1;
            rx_state_d = RX_WAITHI;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
      end
      RX_WAITHI: begin
        if (rx_s) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Inter-byte gap timer: only counts while waiting for an argument byte on an idle line
  always_comb begin
    gap_run    = (frame_state_q != F_OPCODE) && (rx_state_q == RX_IDLE);
    gap_expire = gap_run && !start_det && (gap_q == GAP_W'(GAP_TIMEOUT - 1));
    if (!gap_run || byte_valid_q || start_det || gap_expire) begin
      gap_d = '0;
    end else begin
      gap_d = gap_q + GAP_W'(1);
    end
  end

  // Frame assembly: byte errors first, then received bytes, then gap expiry
  always_comb begin
    frame_state_d = frame_state_q;
    opcode_d      = opcode_q;
    arg_hi_d      = arg_hi_q;
    command_d     = command_q;
    argument_d    = argument_q;
    rx_ready_d    = 1'b0;
    frame_error_d = 1'b0;
    if (byte_err_q) begin
      frame_error_d = 1'b1;
      frame_state_d = F_OPCODE;
    end else if (byte_valid_q) begin
      case (frame_state_q)
        F_OPCODE: begin
          if (shift_q[3:0] == 4'hF || shift_q[3:0] == 4'h7) begin
            opcode_d      = shift_q;
            frame_state_d = F_ARG_HI;
          end else begin
            command_d  = shift_q;
            argument_d = 16'h0000;
            rx_ready_d = 1'b1;
          end
        end
        F_ARG_HI: begin
          arg_hi_d      = shift_q;
          frame_state_d = F_ARG_LO;
        end
        F_ARG_LO: begin
          command_d     = opcode_q;
          argument_d    = {arg_hi_q, shift_q};
          rx_ready_d    = 1'b1;
          frame_state_d = F_OPCODE;
        end
        default: frame_state_d = F_OPCODE;
      endcase
    end else if (gap_expire) begin
      frame_error_d = 1'b1;
      frame_state_d = F_OPCODE;
    end
  end

  // State registers; synchroniser flops reset to the idle line level
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_state_q    <= RX_IDLE;
      bit_cnt_q     <= '0;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'h00;
      byte_valid_q  <= 1'b0;
      byte_err_q    <= 1'b0;
      frame_state_q <= F_OPCODE;
      gap_q         <= '0;
      opcode_q      <= 8'h00;
      arg_hi_q      <= 8'h00;
      command_q     <= 8'h00;
      argument_q    <= 16'h0000;
      rx_ready_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      rx_prev_q     <= rx_prev_d;
      rx_state_q    <= rx_state_d;
      bit_cnt_q     <= bit_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      byte_valid_q  <= byte_valid_d;
      byte_err_q    <= byte_err_d;
      frame_state_q <= frame_state_d;
      gap_q         <= gap_d;
      opcode_q      <= opcode_d;
      arg_hi_q      <= arg_hi_d;
      command_q     <= command_d;
      argument_q    <= argument_d;
      rx_ready_q    <= rx_ready_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign Command     = command_q;
  assign Argument    = argument_q;
  assign Rx_Ready    = rx_ready_q;
  assign Frame_Error = frame_error_q;
  assign Busy        = (rx_state_q != RX_IDLE) || (frame_state_q != F_OPCODE);

endmodule

// File: tb/tb_command_frame_receiver.sv
// tb_command_frame_receiver
// Drives UART bytes into the receiver and compares delivered frames and error
// pulses against a frame-level model of the command protocol.
module tb_command_frame_receiver;

  localparam int CPB = 16;
  localparam int GAP = 320;

  logic        clk;
  logic        reset_b;
  logic        RsRx;
  logic [7:0]  Command;
  logic [15:0] Argument;
  logic        Rx_Ready;
  logic        Frame_Error;
  logic        Busy;

  int checks;
  int failures;

  logic [7:0]  got_cmd[$];
  logic [15:0] got_arg[$];
  int          ready_count;
  int          err_count;
  bit          overlap_seen;
  bit          busy_seen;

  command_frame_receiver #(
    .CLKS_PER_BIT(CPB),
    .GAP_TIMEOUT (GAP)
  ) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .RsRx       (RsRx),
    .Command    (Command),
    .Argument   (Argument),
    .Rx_Ready   (Rx_Ready),
    .Frame_Error(Frame_Error),
    .Busy       (Busy)
  );

  // 10 ns clock; posedges at 5, 15, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Event monitor, sampling 2 ns after each rising edge
  always begin
    @(posedge clk);
    #2;
    if (Rx_Ready) begin
      got_cmd.push_back(Command);
      got_arg.push_back(Argument);
      ready_count++;
    end
    if (Frame_Error) err_count++;
    if (Rx_Ready && Frame_Error) overlap_seen = 1'b1;
    if (Busy) busy_seen = 1'b1;
  end

  // Hard time limit so the run can never hang
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit needs_arg(input logic [7:0] op);
    return (op[3:0] == 4'hF) || (op[3:0] == 4'h7);
  endfunction

  task automatic idle(input int n);
    RsRx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    RsRx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RsRx = b[i];
      repeat (CPB) @(negedge clk);
    end
    RsRx = stop_bit;
    repeat (CPB) @(negedge clk);
    RsRx = 1'b1;
  endtask

  task automatic test_reset;
    reset_b = 1'b0;
    RsRx = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (Command !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_command: got %h expected 00", Command);
    end
    checks++;
    if (Argument !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_argument: got %h expected 0000", Argument);
    end
    checks++;
    if (Rx_Ready !== 1'b0 || Frame_Error !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_pulses: got %b%b expected 00", Rx_Ready, Frame_Error);
    end
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_busy: got %b expected 0", Busy);
    end
    reset_b = 1'b1;
    idle(5);
  endtask

  task automatic test_single_opcode;
    int r0 = ready_count;
    int e0 = err_count;
    uart_send(8'h04, 1'b1);
    idle(4);
    checks++;
    if (ready_count !== r0 + 1) begin
      failures++;
      $display("[TB] FAIL single_ready_count: got %0d expected %0d", ready_count - r0, 1);
    end
    checks++;
    if (got_cmd.size() == 0 || got_cmd[$] !== 8'h04 || got_arg[$] !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL single_frame: got %h/%h expected 04/0000", Command, Argument);
    end
    checks++;
    if (err_count !== e0) begin
      failures++;
      $display("[TB] FAIL single_no_error: got %0d expected 0", err_count - e0);
    end
  endtask

  task automatic test_back_to_back;
    int r0 = ready_count;
    uart_send(8'h0F, 1'b1);
    uart_send(8'h12, 1'b1);
    checks++;
    if (ready_count !== r0) begin
      failures++;
      $display("[TB] FAIL b2b_early_ready: got %0d expected 0", ready_count - r0);
    end
    uart_send(8'h34, 1'b1);
    idle(4);
    checks++;
    if (ready_count !== r0 + 1) begin
      failures++;
      $display("[TB] FAIL b2b_ready_count: got %0d expected 1", ready_count - r0);
    end
    checks++;
    if (Command !== 8'h0F || Argument !== 16'h1234) begin
      failures++;
      $display("[TB] FAIL b2b_frame: got %h/%h expected 0F/1234", Command, Argument);
    end
  endtask

  task automatic test_bad_stop;
    int r0 = ready_count;
    int e0 = err_count;
    uart_send(8'h07, 1'b0);
    idle(6);
    checks++;
    if (err_count !== e0 + 1 || ready_count !== r0) begin
      failures++;
      $display("[TB] FAIL badstop_pulses: got err=%0d rdy=%0d expected err=1 rdy=0",
               err_count - e0, ready_count - r0);
    end
    uart_send(8'h07, 1'b1);
    uart_send(8'hAB, 1'b1);
    uart_send(8'hCD, 1'b1);
    idle(4);
    checks++;
    if (Command !== 8'h07 || Argument !== 16'hABCD || ready_count !== r0 + 1) begin
      failures++;
      $display("[TB] FAIL badstop_recover: got %h/%h expected 07/ABCD", Command, Argument);
    end
  endtask

  task automatic test_gap_timeout;
    int r0 = ready_count;
    int seen_at = 0;
    uart_send(8'h17, 1'b1);
    uart_send(8'hAB, 1'b1);
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (Frame_Error) begin
        seen_at = i;
        break;
      end
    end
    checks++;
    if (seen_at < 300 || seen_at > 330) begin
      failures++;
      $display("[TB] FAIL gap_error_time: got %0d expected 300..330 idle cycles", seen_at);
    end
    idle(3);
    checks++;
    if (Busy !== 1'b0 || ready_count !== r0) begin
      failures++;
      $display("[TB] FAIL gap_discard: got busy=%b rdy=%0d expected busy=0 rdy=0",
               Busy, ready_count - r0);
    end
    uart_send(8'h0D, 1'b1);
    idle(4);
    checks++;
    if (Command !== 8'h0D || Argument !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL gap_recover: got %h/%h expected 0D/0000", Command, Argument);
    end
  endtask

  task automatic test_false_start;
    int r0 = ready_count;
    int e0 = err_count;
    busy_seen = 1'b0;
    RsRx = 1'b0;
    repeat (5) @(negedge clk);
    idle(40);
    checks++;
    if (ready_count !== r0 || err_count !== e0) begin
      failures++;
      $display("[TB] FAIL false_start_events: got rdy=%0d err=%0d expected 0/0",
               ready_count - r0, err_count - e0);
    end
    checks++;
    if (Busy !== 1'b0 || busy_seen !== 1'b1) begin
      failures++;
      $display("[TB] FAIL false_start_busy: got now=%b seen=%b expected 0/1", Busy, busy_seen);
    end
  endtask

  task automatic test_reset_mid_frame;
    uart_send(8'h0F, 1'b1);
    uart_send(8'hAA, 1'b1);
    RsRx = 1'b0;
    repeat (CPB) @(negedge clk);
    RsRx = 1'b1;
    repeat (CPB * 3) @(negedge clk);
    checks++;
    if (Busy !== 1'b1 || Command === 8'h00) begin
      failures++;
      $display("[TB] FAIL pre_reset_state: got busy=%b cmd=%h expected busy=1 cmd!=00",
               Busy, Command);
    end
    reset_b = 1'b0;
    #1;
    checks++;
    if (Command !== 8'h00 || Argument !== 16'h0000 || Rx_Ready !== 1'b0 ||
        Frame_Error !== 1'b0 || Busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset_outputs: got %h/%h/%b%b%b expected 00/0000/000",
               Command, Argument, Rx_Ready, Frame_Error, Busy);
    end
    RsRx = 1'b1;
    repeat (5) @(negedge clk);
    reset_b = 1'b1;
    idle(10);
    uart_send(8'h0F, 1'b1);
    uart_send(8'h00, 1'b1);
    uart_send(8'h01, 1'b1);
    idle(4);
    checks++;
    if (Command !== 8'h0F || Argument !== 16'h0001) begin
      failures++;
      $display("[TB] FAIL post_reset_frame: got %h/%h expected 0F/0001", Command, Argument);
    end
  endtask

  task automatic test_random_frames;
    logic [7:0]  exp_cmd[$];
    logic [15:0] exp_arg[$];
    logic [7:0]  op, hi, lo;
    int base = got_cmd.size();
    int e0 = err_count;
    int exp_err = 0;
    for (int f = 0; f < 20; f++) begin
      op = 8'($urandom);
      if (($urandom_range(0, 2)) == 0) op[3:0] = ($urandom_range(0, 1) == 0) ? 4'hF : 4'h7;
      hi = 8'($urandom);
      lo = 8'($urandom);
      uart_send(op, 1'b1);
      if (needs_arg(op)) begin
        if ($urandom_range(0, 5) == 0) begin
          idle(400);
          exp_err++;
        end else begin
          idle($urandom_range(0, 40));
          uart_send(hi, 1'b1);
          idle($urandom_range(0, 40));
          uart_send(lo, 1'b1);
          exp_cmd.push_back(op);
          exp_arg.push_back({hi, lo});
        end
      end else begin
        exp_cmd.push_back(op);
        exp_arg.push_back(16'h0000);
      end
      idle($urandom_range(0, 30));
    end
    idle(4);
    checks++;
    if (got_cmd.size() - base !== exp_cmd.size()) begin
      failures++;
      $display("[TB] FAIL random_frame_count: got %0d expected %0d",
               got_cmd.size() - base, exp_cmd.size());
    end
    checks++;
    if (err_count - e0 !== exp_err) begin
      failures++;
      $display("[TB] FAIL random_error_count: got %0d expected %0d", err_count - e0, exp_err);
    end
    for (int k = 0; k < exp_cmd.size() && base + k < got_cmd.size(); k++) begin
      checks++;
      if (got_cmd[base + k] !== exp_cmd[k] || got_arg[base + k] !== exp_arg[k]) begin
        failures++;
        $display("[TB] FAIL random_frame_%0d: got %h/%h expected %h/%h", k,
                 got_cmd[base + k], got_arg[base + k], exp_cmd[k], exp_arg[k]);
      end
    end
  endtask

  task automatic test_no_overlap;
    checks++;
    if (overlap_seen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ready_error_overlap: got %b expected 0", overlap_seen);
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    ready_count  = 0;
    err_count    = 0;
    overlap_seen = 1'b0;
    busy_seen    = 1'b0;
    reset_b      = 1'b0;
    RsRx         = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_opcode();
    test_back_to_back();
    test_bad_stop();
    test_gap_timeout();
    test_false_start();
    test_reset_mid_frame();
    test_random_frames();
    test_no_overlap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
